// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one external W-bit adder among four requesters.
// Operands are held on the adder for SETTLE_CYCLES periods, then sum/carry are returned with the owner ID.
module adder_share_arbiter #(
    parameter int W             = 16,
    parameter int NREQ          = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    input  logic [NREQ-1:0]   req_op,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    output logic              add_cin,
    input  logic [W-1:0]      add_s,
    input  logic              add_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_s,
    output logic              rsp_cout,
    output logic [1:0]        rsp_id,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [1:0]  r_lastGrant;
    logic [7:0]  r_count;
    logic [1:0]  w_sel;
    logic        w_found;
    logic        w_transfer;
    logic [W-1:0] w_opA;
    logic [W-1:0] w_opB;

    // Search starts one past the last winner so every waiting requester is reached within four grants.
    always_comb begin
        logic [1:0] idx;
        w_found = 1'b0;
        w_sel   = 2'd0;
        idx     = 2'd0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = r_lastGrant + 2'(k);
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_sel   = idx;
            end
        end
    end

    assign w_transfer = (r_state == IDLE) && w_found;
    assign w_opA      = req_a[w_sel*W +: W];
    assign w_opB      = req_b[w_sel*W +: W];

    always_comb begin
        req_ready = '0;
        if (w_transfer && rst_n) begin
            req_ready[w_sel] = 1'b1;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_found)          w_nextState = SETTLE;
            SETTLE:  if (r_count == 8'd0)  w_nextState = RESP;
            RESP:    if (rsp_ready)        w_nextState = IDLE;
            default:                       w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            busy    <= 1'b0;
        end else begin
            r_state <= w_nextState;
            busy    <= (w_nextState != IDLE);
        end
    end

    // Subtraction is A + ~B + 1, so the operand is inverted here and carry-in forced high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lastGrant <= 2'd3;
            r_count     <= 8'd0;
            add_a       <= '0;
            add_b       <= '0;
            add_cin     <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_s       <= '0;
            rsp_cout    <= 1'b0;
            rsp_id      <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_transfer) begin
                        add_a       <= w_opA;
                        if (req_op[w_sel]) begin
                            add_b   <= ~w_opB;
                            add_cin <= 1'b1;
                        end else begin
                            add_b   <= w_opB;
                            add_cin <= req_cin[w_sel];
                        end
                        rsp_id      <= w_sel;
                        r_lastGrant <= w_sel;
                        r_count     <= 8'(SETTLE_CYCLES - 1);
                    end
                end
                SETTLE: begin
                    if (r_count == 8'd0) begin
                        rsp_s     <= add_s;
                        rsp_cout  <= add_cout;
                        rsp_valid <= 1'b1;
                    end else begin
                        r_count <= r_count - 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
